z80_bus_responder: RTL and testbench

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_bus_responder.sv | 203 ++++++++++++++++++++
 tb/tb_z80_bus_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_responder.sv
// z80_bus_responder
// -----------------
// Simulated memory and I/O target for a Z80-style CPU bus. A 64 KiB byte
// store answers memory cycles directly and I/O cycles through a single page
// of that store ({IO_PAGE, port}). Interrupt acknowledge cycles return a
// fixed vector. A configurable number of wait states is requested on
// wait_n before each memory or I/O access completes. A backdoor port lets
// the environment preload and inspect the store without using the CPU bus.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   A         : CPU address
//   dout      : CPU write data
//   mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n : CPU strobes, active low
//   di        : read data returned to the CPU (holds its last loaded value)
//   wait_n    : wait request to the CPU, active low
//   bd_we     : backdoor write enable
//   bd_addr   : backdoor address
//   bd_wdata  : backdoor write data
//   bd_rdata  : backdoor read data, one cycle latency, pre-write contents
module z80_bus_responder #(
   parameter int         MEM_WAIT    = 0,
   parameter int         IO_WAIT     = 1,
   parameter logic [7:0] IO_PAGE     = 8'h10,
   parameter logic [7:0] INTA_VECTOR = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        rfsh_n,
   output logic [7:0]  di,
   output logic        wait_n,
   input  logic        bd_we,
   input  logic [15:0] bd_addr,
   input  logic [7:0]  bd_wdata,
   output logic [7:0]  bd_rdata
);

   localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
   localparam logic [3:0] IO_N  = 4'(IO_WAIT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      HOLD
   } state_t;

   logic [7:0]  storage [0:65535];

   state_t      state, state_next;
   logic [3:0]  count, count_next;
   logic [15:0] addr, addr_next;
   logic        is_write, is_write_next;
   logic        is_ack, is_ack_next;
   logic        blocked, blocked_next;
   logic        wait_n_next;
   logic        cpu_we;
   logic        load_data;
   logic        load_vector;

   logic        mem_req, io_req, ack_req, req;
   logic [3:0]  sel_wait;
   logic [15:0] sel_addr;

   // Request decode. Refresh cycles are excluded from memory requests, and
   // when both mreq_n and iorq_n are low outside M1 the I/O interpretation
   // takes priority over the memory one.
   always_comb begin
      mem_req  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
      io_req   = !iorq_n && m1_n && (!rd_n || !wr_n);
      ack_req  = !iorq_n && !m1_n;
      req      = mem_req || io_req || ack_req;
      sel_wait = 4'd0;
      sel_addr = A;
      if (io_req) begin
         sel_wait = IO_N;
         sel_addr = {IO_PAGE, A[7:0]};
      end else if (mem_req) begin
         sel_wait = MEM_N;
      end
   end

   // Next-state logic. 'blocked' is raised by reset and cleared by the first
   // cycle without a request, so a request still asserted across reset is
   // parked in HOLD instead of being serviced a second time.
   always_comb begin
      state_next    = state;
      count_next    = count;
      addr_next     = addr;
      is_write_next = is_write;
      is_ack_next   = is_ack;
      blocked_next  = blocked && req;
      wait_n_next   = wait_n;
      cpu_we        = 1'b0;
      load_data     = 1'b0;
      load_vector   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (blocked) begin
                  state_next = HOLD;
               end else begin
                  addr_next     = sel_addr;
                  is_write_next = !wr_n && !ack_req;
                  is_ack_next   = ack_req;
                  if (!ack_req && sel_wait != 4'd0) begin
                     state_next  = WAIT;
                     count_next  = sel_wait;
                     wait_n_next = 1'b0;
                  end else begin
                     state_next = ACCESS;
                  end
               end
            end
         end
         WAIT: begin
            // The counter value is the number of wait cycles still owed,
            // so leaving at 1 keeps wait_n low for exactly N cycles.
            if (!req) begin
               state_next  = IDLE;
               count_next  = 4'd0;
               wait_n_next = 1'b1;
            end else if (count <= 4'd1) begin
               state_next  = ACCESS;
               count_next  = 4'd0;
               wait_n_next = 1'b1;
            end else begin
               count_next = count - 4'd1;
            end
         end
         ACCESS: begin
            cpu_we      = is_write;
            load_data   = !is_write && !is_ack;
            load_vector = is_ack;
            state_next  = HOLD;
         end
         HOLD: begin
            if (!req) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register and CPU-visible outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 4'd0;
         addr     <= 16'h0000;
         is_write <= 1'b0;
         is_ack   <= 1'b0;
         blocked  <= 1'b1;
         wait_n   <= 1'b1;
         di       <= 8'hFF;
      end else begin
         state    <= state_next;
         count    <= count_next;
         addr     <= addr_next;
         is_write <= is_write_next;
         is_ack   <= is_ack_next;
         blocked  <= blocked_next;
         wait_n   <= wait_n_next;
         if (load_data) begin
            di <= storage[addr];
         end else if (load_vector) begin
            di <= INTA_VECTOR;
         end
      end
   end

   // Byte store. The CPU write is placed last so it wins over a backdoor
   // write to the same address in the same cycle; reset discards it.
   always_ff @(posedge clk) begin
      if (bd_we) begin
         storage[bd_addr] <= bd_wdata;
      end
      if (cpu_we && !reset) begin
         storage[addr] <= dout;
      end
   end

   // Backdoor read port, registered, showing contents before this edge's writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         bd_rdata <= 8'h00;
      end else begin
         bd_rdata <= storage[bd_addr];
      end
   end

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder
// --------------------
// Self-checking bench for z80_bus_responder. Three instances share one CPU
// bus and backdoor: u0 with default parameters, u2 with MEM_WAIT=2 and u3
// with MEM_WAIT=3. Expected bytes are queued when stimulus is driven and
// popped when the relevant instance produces its output.
module tb_z80_bus_responder;

   logic        clk;
   logic        reset;
   logic [15:0] A;
   logic [7:0]  dout;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [7:0]  bd_wdata;

   logic [7:0]  di_0, di_2, di_3;
   logic        wait_n_0, wait_n_2, wait_n_3;
   logic [7:0]  bd_rdata_0, bd_rdata_2, bd_rdata_3;

   int          passed = 0;
   int          total  = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_byte;

   z80_bus_responder u0 (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .m1_n(m1_n), .rfsh_n(rfsh_n), .di(di_0), .wait_n(wait_n_0),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata_0)
   );

   z80_bus_responder #(.MEM_WAIT(2)) u2 (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .m1_n(m1_n), .rfsh_n(rfsh_n), .di(di_2), .wait_n(wait_n_2),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata_2)
   );

   z80_bus_responder #(.MEM_WAIT(3)) u3 (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .m1_n(m1_n), .rfsh_n(rfsh_n), .di(di_3), .wait_n(wait_n_3),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
      wr_n   = 1'b1; m1_n   = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_idle();
      tick();
      tick();
      total++; if (di_0 !== 8'hFF) $display("[TB] FAIL reset_di0: got %h required FF", di_0); else passed++;
      total++; if (wait_n_0 !== 1'b1) $display("[TB] FAIL reset_wait0: got %b required 1", wait_n_0); else passed++;
      total++; if (bd_rdata_0 !== 8'h00) $display("[TB] FAIL reset_bd0: got %h required 00", bd_rdata_0); else passed++;
      total++; if (di_3 !== 8'hFF) $display("[TB] FAIL reset_di3: got %h required FF", di_3); else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mem_read();
      bd_write(16'hDCA6, 8'h49);
      A = 16'hDCA6; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back(8'h49);
      tick();
      total++; if (di_0 !== 8'hFF) $display("[TB] FAIL rd_early_di: got %h required FF", di_0); else passed++;
      total++; if (wait_n_0 !== 1'b1) $display("[TB] FAIL rd_wait0_c1: got %b required 1", wait_n_0); else passed++;
      total++; if (wait_n_2 !== 1'b0) $display("[TB] FAIL rd_wait2_c1: got %b required 0", wait_n_2); else passed++;
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (di_0 !== exp_byte) $display("[TB] FAIL rd_di: got %h required %h", di_0, exp_byte); else passed++;
      total++; if (wait_n_0 !== 1'b1) $display("[TB] FAIL rd_wait0_c2: got %b required 1", wait_n_0); else passed++;
      bus_idle();
      tick();
      // u2 was still waiting when the request dropped: abort path
      total++; if (wait_n_2 !== 1'b1) $display("[TB] FAIL abort_wait2: got %b required 1", wait_n_2); else passed++;
      total++; if (di_2 !== 8'hFF) $display("[TB] FAIL abort_di2: got %h required FF", di_2); else passed++;
      tick();
   endtask

   task automatic test_mem_write_wait();
      int lo = 0;
      A = 16'h1234; dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wait_n_2 === 1'b0) lo++;
         if (i == 3) bd_addr = 16'h1234;
         if (i == 4) begin
            exp_byte = exp_q.pop_front();
            total++; if (bd_rdata_2 !== exp_byte) $display("[TB] FAIL wr_bd_after: got %h required %h", bd_rdata_2, exp_byte); else passed++;
            bd_we = 1'b1; bd_wdata = 8'h00;
         end
         if (i == 5) begin
            exp_byte = exp_q.pop_front();
            total++; if (bd_rdata_2 !== exp_byte) $display("[TB] FAIL wr_bd_prewrite: got %h required %h", bd_rdata_2, exp_byte); else passed++;
            bd_we = 1'b0;
         end
      end
      total++; if (lo != 2) $display("[TB] FAIL wr_wait_count: got %0d required 2", lo); else passed++;
      bus_idle();
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (bd_rdata_2 !== exp_byte) $display("[TB] FAIL wr_single: got %h required %h", bd_rdata_2, exp_byte); else passed++;
      total++; if (di_2 !== 8'hFF) $display("[TB] FAIL wr_di2: got %h required FF", di_2); else passed++;
      tick();
   endtask

   task automatic test_io();
      int lo = 0;
      bd_write(16'h1040, 8'h5C);
      bd_write(16'h0040, 8'h3C);
      A = 16'hAB3F; dout = 8'hA7; iorq_n = 1'b0; wr_n = 1'b0;
      exp_q.push_back(8'hA7);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wait_n_0 === 1'b0) lo++;
      end
      total++; if (lo != 1) $display("[TB] FAIL io_wait_count: got %0d required 1", lo); else passed++;
      bus_idle();
      tick();
      bd_addr = 16'h103F;
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (bd_rdata_0 !== exp_byte) $display("[TB] FAIL io_store: got %h required %h", bd_rdata_0, exp_byte); else passed++;
      A = 16'h553F; iorq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back(8'hA7);
      tick();
      tick();
      total++; if (di_0 !== 8'h49) $display("[TB] FAIL io_rd_early: got %h required 49", di_0); else passed++;
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (di_0 !== exp_byte) $display("[TB] FAIL io_rd_di: got %h required %h", di_0, exp_byte); else passed++;
      bus_idle();
      tick();
      // both strobes low outside M1 must be an I/O read of port 40
      A = 16'h0040; mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back(8'h5C);
      tick();
      total++; if (wait_n_0 !== 1'b0) $display("[TB] FAIL mixed_wait: got %b required 0", wait_n_0); else passed++;
      tick();
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (di_0 !== exp_byte) $display("[TB] FAIL mixed_di: got %h required %h", di_0, exp_byte); else passed++;
      bus_idle();
      tick();
   endtask

   task automatic test_refresh();
      A = 16'h1040; dout = 8'h00; mreq_n = 1'b0; rfsh_n = 1'b0;
      exp_q.push_back(8'h5C);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (wait_n_0 !== 1'b1) $display("[TB] FAIL rfsh_wait: got %b required 1", wait_n_0); else passed++;
      end
      exp_byte = exp_q.pop_front();
      total++; if (di_0 !== exp_byte) $display("[TB] FAIL rfsh_di: got %h required %h", di_0, exp_byte); else passed++;
      bus_idle();
      bd_addr = 16'h1040;
      tick();
      total++; if (bd_rdata_0 !== 8'h5C) $display("[TB] FAIL rfsh_store: got %h required 5C", bd_rdata_0); else passed++;
   endtask

   task automatic test_inta();
      iorq_n = 1'b0; m1_n = 1'b0;
      exp_q.push_back(8'hFF);
      tick();
      total++; if (wait_n_0 !== 1'b1) $display("[TB] FAIL inta_wait: got %b required 1", wait_n_0); else passed++;
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (di_0 !== exp_byte) $display("[TB] FAIL inta_di: got %h required %h", di_0, exp_byte); else passed++;
      bus_idle();
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int lo = 0;
      bd_write(16'h4321, 8'h77);
      A = 16'h4321; dout = 8'h11; mreq_n = 1'b0; wr_n = 1'b0;
      exp_q.push_back(8'h77);
      tick();
      total++; if (wait_n_3 !== 1'b0) $display("[TB] FAIL rst_wait_before: got %b required 0", wait_n_3); else passed++;
      tick();
      reset = 1'b1;
      tick();
      total++; if (wait_n_3 !== 1'b1) $display("[TB] FAIL rst_wait_after: got %b required 1", wait_n_3); else passed++;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wait_n_3 === 1'b0) lo++;
      end
      total++; if (lo != 0) $display("[TB] FAIL rst_no_rewait: got %0d required 0", lo); else passed++;
      total++; if (di_3 !== 8'hFF) $display("[TB] FAIL rst_di3: got %h required FF", di_3); else passed++;
      bus_idle();
      bd_addr = 16'h4321;
      tick();
      exp_byte = exp_q.pop_front();
      total++; if (bd_rdata_3 !== exp_byte) $display("[TB] FAIL rst_store3: got %h required %h", bd_rdata_3, exp_byte); else passed++;
      total++; if (bd_rdata_2 !== 8'h77) $display("[TB] FAIL rst_store2: got %h required 77", bd_rdata_2); else passed++;
      total++; if (bd_rdata_0 !== 8'h11) $display("[TB] FAIL rst_store0: got %h required 11", bd_rdata_0); else passed++;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      A = 16'h0000; dout = 8'h00;
      bd_we = 1'b0; bd_addr = 16'h0000; bd_wdata = 8'h00;
      bus_idle();
      test_reset();
      test_mem_read();
      test_mem_write_wait();
      test_io();
      test_refresh();
      test_inta();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
